// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// IfIdReg -- IF/ID pipeline register (module if_id_reg)
//
// Sits between the program-counter register and instruction memory on one
// side and the decode stage on the other. On every rising clock edge it
// captures the fetched instruction, the PC it came from, and PC+4. Decode
// then sees those values for the whole of the next cycle.
//
// The register can be held (stall), can load a bubble (flush), and always
// loads one bubble on the first edge after reset. Two saturating counters
// record how many real instructions and how many flush bubbles were loaded.
// They are used for bring-up debug.
//
// Parameters
//   WIDTH  address and instruction width
//   CNT_W  width of each performance counter
//   NOP    instruction word presented to decode for a bubble
//
// Ports
//   clk           system clock; the block samples on the rising edge
//   reset         synchronous, active-high reset
//   pc_in         current PC; the PC register updates it on the falling edge
//   instr_in      instruction memory read data for pc_in
//   stall         hazard unit request to hold the current contents
//   flush         branch/jump taken; discard the fetched instruction
//   pc_out        PC of the instruction in decode
//   pc_plus4_out  pc_out + 4 (modulo 2^WIDTH), held in its own register
//   instr_out     instruction in decode (NOP for a bubble)
//   valid_out     1 = real instruction, 0 = bubble
//   fetch_cnt     saturating count of real instructions loaded
//   bubble_cnt    saturating count of flush bubbles loaded
// ---------------------------------------------------------------------------
module if_id_reg #(
  parameter int                WIDTH = 32,
  parameter int                CNT_W = 16,
  parameter logic [WIDTH-1:0]  NOP   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [WIDTH-1:0]  instr_in,
  input  logic              stall,
  input  logic              flush,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  pc_plus4_out,
  output logic [WIDTH-1:0]  instr_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // This is the single action chosen for the current edge, after the
  // priority has been applied. Reset is not listed here because it is
  // handled directly in the register process.
  typedef enum logic [1:0] {
    ActLoad   = 2'd0,
    ActHold   = 2'd1,
    ActFirst  = 2'd2,
    ActFlush  = 2'd3
  } action_e;

  action_e          action;

  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] pcPlus4_q,  pcPlus4_d;
  logic [WIDTH-1:0] instr_q,    instr_d;
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic             first_q,    first_d;

  logic [WIDTH-1:0] pcPlus4In;

  // PC+4 is computed from the incoming PC. The sum wraps naturally at the
  // register width, so 32'hFFFF_FFFC produces 0.
  assign pcPlus4In = pc_in + PC_STEP;

  // The priority between the control inputs is flush, then the post-reset
  // bubble, then stall, then a normal load. A flush must win over a stall:
  // the fetched instruction is on the wrong path, so holding it would leave
  // a wrong-path instruction in decode.
  always_comb begin
    action = ActLoad;
    if (flush) begin
      action = ActFlush;
    end else if (first_q) begin
      action = ActFirst;
    end else if (stall) begin
      action = ActHold;
    end
  end

  // This process computes the next-state values from the chosen action.
  // The first edge after reset loads a bubble because the PC register has
  // not yet driven a defined PC. That bubble is deliberately left out of
  // bubble_cnt, so the counter only reflects flushes. first_q lasts for
  // exactly one edge, whichever action is taken on that edge.
  always_comb begin
    pc_d        = pc_q;
    pcPlus4_d   = pcPlus4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    fetchCnt_d  = fetchCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    first_d     = 1'b0;

    unique case (action)
      ActFlush: begin
        pc_d      = pc_in;
        pcPlus4_d = pcPlus4In;
        instr_d   = NOP;
        valid_d   = 1'b0;
        if (bubbleCnt_q != CNT_MAX) begin
          bubbleCnt_d = bubbleCnt_q + CNT_ONE;
        end
      end
      ActFirst: begin
        pc_d      = pc_in;
        pcPlus4_d = pcPlus4In;
        instr_d   = NOP;
        valid_d   = 1'b0;
      end
      ActHold: begin
        // Hold every output. The hazard unit freezes the PC upstream.
      end
      default: begin
        pc_d      = pc_in;
        pcPlus4_d = pcPlus4In;
        instr_d   = instr_in;
        valid_d   = 1'b1;
        if (fetchCnt_q != CNT_MAX) begin
          fetchCnt_d = fetchCnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // State register with synchronous reset. Reset wins over every other
  // input. It leaves a bubble in decode and arms first_q, so a second
  // bubble follows on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      pcPlus4_q   <= PC_STEP;
      instr_q     <= NOP;
      valid_q     <= 1'b0;
      fetchCnt_q  <= '0;
      bubbleCnt_q <= '0;
      first_q     <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      pcPlus4_q   <= pcPlus4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      fetchCnt_q  <= fetchCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      first_q     <= first_d;
    end
  end

  // Every output comes straight from a register, so no input has a
  // combinational path to an output.
  assign pc_out       = pc_q;
  assign pc_plus4_out = pcPlus4_q;
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign fetch_cnt    = fetchCnt_q;
  assign bubble_cnt   = bubbleCnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// TbIfIdReg -- testbench for if_id_reg (module tb_if_id_reg)
//
// The DUT is built with CNT_W=4 so that counter saturation can be reached
// quickly. For every step, the bench drives the inputs just after the
// falling edge, the way the PC register does. It then works out the
// expected register contents from its own reference model and pushes them
// onto a scoreboard queue. One time unit after the rising edge, it pops the
// queue and compares the result against every output.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

  localparam int          WIDTH   = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  pc_in;
  logic [WIDTH-1:0]  instr_in;
  logic              stall;
  logic              flush;
  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  pc_plus4_out;
  logic [WIDTH-1:0]  instr_out;
  logic              valid_out;
  logic [CNT_W-1:0]  fetch_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    int          fcnt;
    int          bcnt;
  } exp_t;

  exp_t scoreboard[$];

  // Reference model state.
  logic [31:0] mPc, mPc4, mInstr;
  logic        mValid, mFirst;
  int          mFcnt, mBcnt;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  if_id_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .NOP   (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .instr_in     (instr_in),
    .stall        (stall),
    .flush        (flush),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
    end
  endtask

  // Drive one step and push the expected result onto the scoreboard.
  task automatic applyStimulus(input string tag, input logic rst, input logic stl,
                               input logic fls, input logic [31:0] pc,
                               input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    stall    = stl;
    flush    = fls;
    pc_in    = pc;
    instr_in = ins;
    if (rst) begin
      mPc = 32'd0; mPc4 = 32'd4; mInstr = NOP; mValid = 1'b0;
      mFcnt = 0; mBcnt = 0; mFirst = 1'b1;
    end else if (fls) begin
      mPc = pc; mPc4 = pc + 32'd4; mInstr = NOP; mValid = 1'b0;
      if (mBcnt < CNT_MAX) mBcnt++;
      mFirst = 1'b0;
    end else if (mFirst) begin
      mPc = pc; mPc4 = pc + 32'd4; mInstr = NOP; mValid = 1'b0;
      mFirst = 1'b0;
    end else if (!stl) begin
      mPc = pc; mPc4 = pc + 32'd4; mInstr = ins; mValid = 1'b1;
      if (mFcnt < CNT_MAX) mFcnt++;
    end
    e.tag = tag; e.pc = mPc; e.pc4 = mPc4; e.instr = mInstr;
    e.valid = mValid; e.fcnt = mFcnt; e.bcnt = mBcnt;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it against every output.
  task automatic checkOutput();
    exp_t e;
    checkCount++;
    assert (scoreboard.size() > 0) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = scoreboard.pop_front();
    cmp(e.tag, "pc_out",       pc_out,       e.pc);
    cmp(e.tag, "pc_plus4_out", pc_plus4_out, e.pc4);
    cmp(e.tag, "instr_out",    instr_out,    e.instr);
    cmp(e.tag, "valid_out",    {31'd0, valid_out}, {31'd0, e.valid});
    cmp(e.tag, "fetch_cnt",    {28'd0, fetch_cnt},  32'(e.fcnt));
    cmp(e.tag, "bubble_cnt",   {28'd0, bubble_cnt}, 32'(e.bcnt));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    pc_in = '0; instr_in = '0;
    mPc = '0; mPc4 = 32'd4; mInstr = NOP; mValid = 1'b0;
    mFcnt = 0; mBcnt = 0; mFirst = 1'b1;

    // Reset is held for three cycles and then released.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset", 1'b1, 1'b0, 1'b0, 32'd0, 32'h2008_0005); checkOutput();
    end
    applyStimulus("firstBubble", 1'b0, 1'b0, 1'b0, 32'd0, 32'h2008_0005); checkOutput();
    applyStimulus("firstLoad",   1'b0, 1'b0, 1'b0, 32'd0, 32'h2008_0005); checkOutput();

    // This section streams instructions and then applies a stall of three edges.
    applyStimulus("stream4",  1'b0, 1'b0, 1'b0, 32'd4,  32'h2009_0007); checkOutput();
    applyStimulus("stream8",  1'b0, 1'b0, 1'b0, 32'd8,  32'h0128_5020); checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b0, 1'b1, 1'b0, 32'd12, 32'hAC0A_0000); checkOutput();
    end
    applyStimulus("stream12", 1'b0, 1'b0, 1'b0, 32'd12, 32'hAC0A_0000); checkOutput();

    // A flush is applied alone, and then a flush and a stall are applied together.
    applyStimulus("flush",      1'b0, 1'b0, 1'b1, 32'd16, 32'h1000_FFFF); checkOutput();
    applyStimulus("flushStall", 1'b0, 1'b1, 1'b1, 32'd20, 32'h0800_0010); checkOutput();

    // This load checks that PC+4 wraps around to zero.
    applyStimulus("pcWrap", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h2108_0001); checkOutput();

    // Twenty loads drive the 4-bit fetch counter into saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("saturate", 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i * 4), $urandom);
      checkOutput();
    end

    // Reset is asserted during a stall while valid_out is high.
    applyStimulus("preStall",   1'b0, 1'b1, 1'b0, 32'h200, 32'h1234_5678); checkOutput();
    applyStimulus("resetStall", 1'b1, 1'b1, 1'b0, 32'h200, 32'h1234_5678); checkOutput();
    applyStimulus("postReset1", 1'b0, 1'b0, 1'b0, 32'd0,   32'h2008_0005); checkOutput();
    applyStimulus("postReset2", 1'b0, 1'b0, 1'b0, 32'd0,   32'h2008_0005); checkOutput();

    // A flush on the first edge after reset takes priority over the post-reset bubble.
    applyStimulus("reset2",     1'b1, 1'b0, 1'b0, 32'd0,  32'd0); checkOutput();
    applyStimulus("flushFirst", 1'b0, 1'b0, 1'b1, 32'd40, 32'hDEAD_BEEF); checkOutput();
    applyStimulus("afterFirst", 1'b0, 1'b0, 1'b0, 32'd44, 32'hCAFE_F00D); checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
